// File: rtl/peri_apb_arb.sv
// Two-requester round-robin scheduler and APB master for the peripheral bus.
// Latency: req seen in IDLE -> psel next cycle, penable after that, ack two cycles later plus wait states.
// Backpressure: req is held until ack; the slave stalls via pready; a hung slave is aborted after TIMEOUT ACCESS cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req/write/addr/wdata       per-requester request, direction, address and write data (requester i in slice i)
//   ack/rdata/err/timeout_evt  completion pulse to the owner, with read data, error flag and timeout pulse
//   owner                      index of the current or last granted requester
//   psel..pslverr              APB master interface
module peri_apb_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          write,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                owner,
  output logic                timeout_evt,
  output logic                psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit so TIMEOUT=0/1 still elaborates.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_grant;

  // Lone requester wins outright; on a tie the one not served last goes next.
  always_comb begin
    w_grant = req[1];
    if (req == 2'b11) begin
      w_grant = ~r_last_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= 1'b1;
      r_cnt       <= '0;
      ack         <= 2'b00;
      rdata       <= '0;
      err         <= 1'b0;
      owner       <= 1'b0;
      timeout_evt <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
    end else begin
      ack         <= 2'b00;
      timeout_evt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            r_last_gnt <= w_grant;
            owner      <= w_grant;
            paddr      <= w_grant ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
            pwdata     <= w_grant ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
            pwrite     <= write[w_grant];
            psel       <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            rdata   <= pwrite ? '0 : prdata;
            err     <= pslverr;
            psel    <= 1'b0;
            penable <= 1'b0;
            ack     <= owner ? 2'b10 : 2'b01;
            r_state <= ST_RESP;
          end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
            // Hung slave: complete toward the requester with an error instead of waiting forever.
            rdata       <= '0;
            err         <= 1'b1;
            timeout_evt <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            ack         <= owner ? 2'b10 : 2'b01;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peri_apb_arb.sv
module tb_peri_apb_arb;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req;
  logic [1:0]          write;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                err;
  logic                owner;
  logic                timeout_evt;
  logic                psel;
  logic                penable;
  logic [ADDR_W-1:0]   paddr;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        tevt;
    logic        owner;
    int          lat;
  } exp_t;

  exp_t sb[$];

  peri_apb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .owner(owner), .timeout_evt(timeout_evt),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One transfer: m = request mask driven, g = requester expected to win.
  task automatic xfer(input logic [1:0] m, input logic g, input int waits,
                      input logic [31:0] prd, input logic slv, input logic to);
    exp_t        e;
    exp_t        got;
    logic [31:0] ea;
    logic [31:0] ew;
    logic        ewr;
    int          n;
    ea  = g ? addr[63:32] : addr[31:0];
    ew  = g ? wdata[63:32] : wdata[31:0];
    ewr = write[g];
    e.ack   = g ? 2'b10 : 2'b01;
    e.rdata = (to || ewr) ? 32'h0 : prd;
    e.err   = slv | to;
    e.tevt  = to;
    e.owner = g;
    e.lat   = to ? TIMEOUT - 1 : waits;
    sb.push_back(e);

    req = m;
    tick();
    chk("setup_psel_penable", {62'b0, psel, penable}, 64'b10);
    chk("setup_paddr", {32'b0, paddr}, {32'b0, ea});
    chk("setup_pwrite", {63'b0, pwrite}, {63'b0, ewr});
    chk("setup_pwdata", {32'b0, pwdata}, {32'b0, ew});
    chk("setup_owner", {63'b0, owner}, {63'b0, g});
    tick();
    n = 0;
    while (1) begin
      chk("access_psel_penable", {62'b0, psel, penable}, 64'b11);
      chk("access_stable", {pwrite, paddr, pwdata[30:0]}, {ewr, ea, ew[30:0]});
      pready  = (!to && n == waits);
      prdata  = prd;
      pslverr = slv;
      tick();
      if (ack != 2'b00 || n > TIMEOUT + 20) break;
      n++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;

    got = sb.pop_front();
    chk("ack", {62'b0, ack}, {62'b0, got.ack});
    chk("rdata", {32'b0, rdata}, {32'b0, got.rdata});
    chk("err", {63'b0, err}, {63'b0, got.err});
    chk("timeout_evt", {63'b0, timeout_evt}, {63'b0, got.tevt});
    chk("ack_owner", {63'b0, owner}, {63'b0, got.owner});
    chk("ack_latency", 64'(n), 64'(got.lat));
    chk("resp_psel_penable", {62'b0, psel, penable}, 64'b00);

    req = m & ~(g ? 2'b10 : 2'b01);
    tick();
    chk("post_ack_pulse", {62'b0, ack}, 64'b0);
    chk("post_tevt_pulse", {63'b0, timeout_evt}, 64'b0);
    chk("rdata_hold", {32'b0, rdata}, {32'b0, got.rdata});
    chk("err_hold", {63'b0, err}, {63'b0, got.err});
  endtask

  initial begin
    write   = 2'b00;
    addr    = {32'h1000_0100, 32'h1000_0004};
    wdata   = {32'h0000_00FF, 32'h1234_5678};
    prdata  = 32'h0;
    pready  = 1'b0;
    pslverr = 1'b0;
    do_reset();

    // Reset state: every output low.
    chk("reset_ack", {62'b0, ack}, 64'b0);
    chk("reset_ctrl", {59'b0, err, owner, timeout_evt, psel, penable}, 64'b0);
    chk("reset_data", {rdata, paddr}, 64'b0);
    chk("reset_wr", {31'b0, pwrite, pwdata}, 64'b0);

    // 1: requester 0 read, zero wait states.
    xfer(2'b01, 1'b0, 0, 32'hA5A5_0001, 1'b0, 1'b0);

    // 2: both requesting after reset -> strict alternation starting at 0.
    do_reset();
    xfer(2'b11, 1'b0, 0, 32'h0000_0011, 1'b0, 1'b0);
    xfer(2'b11, 1'b1, 1, 32'h0000_0022, 1'b0, 1'b0);
    xfer(2'b11, 1'b0, 0, 32'h0000_0033, 1'b0, 1'b0);
    xfer(2'b11, 1'b1, 2, 32'h0000_0044, 1'b0, 1'b0);

    // 3: requester 1 write with three wait states; rdata forced to 0.
    write = 2'b10;
    xfer(2'b10, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // 4: requester 0 write answered with pslverr.
    write = 2'b01;
    xfer(2'b01, 1'b0, 0, 32'h0, 1'b1, 1'b0);

    // 5: requester 1 read to a hung slave -> timeout abort.
    write = 2'b00;
    xfer(2'b10, 1'b1, 0, 32'hBEEF_CAFE, 1'b0, 1'b1);

    // 6: reset during ACCESS of requester 0, then tie goes to requester 0.
    req = 2'b01;
    tick();
    tick();
    chk("pre_reset_access", {62'b0, psel, penable}, 64'b11);
    rst = 1'b1;
    req = 2'b00;
    tick();
    rst = 1'b0;
    chk("rst_mid_psel_penable", {62'b0, psel, penable}, 64'b00);
    chk("rst_mid_ack", {62'b0, ack}, 64'b0);
    chk("rst_mid_owner", {63'b0, owner}, 64'b0);
    tick();
    chk("rst_mid_no_late_ack", {62'b0, ack}, 64'b0);
    xfer(2'b11, 1'b0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    req = 2'b00;

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peri_apb_arb.md
Name: peri_apb_arb

Overview:
- Two-requester scheduler and APB master in front of the peripheral APB bus (UART/SPI decode side).
- Lets two on-chip requesters (e.g. core load/store port and a DMA/debug engine) share the single peripheral APB slave port.
- Arbitrates round-robin, sequences the APB SETUP/ACCESS phases, returns read data and error, and aborts transfers to a hung slave with a timeout.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 255, max ACCESS cycles with pready low before forced abort; 0 disables timeout

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  2  per-requester request, bit i = requester i; held high until ack[i]
write  in  2  per-requester direction, 1 = write; stable while req high
addr  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
wdata  in  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W]
ack  out  2  one-cycle completion pulse to owning requester
rdata  out  DATA_W  read data, valid in the ack cycle
err  out  1  error flag, valid in the ack cycle
owner  out  1  index of current/last granted requester
timeout_evt  out  1  one-cycle pulse when a transfer is aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (rst=1 at clock edge): FSM=IDLE; all outputs 0; internal last_gnt=1, so requester 0 wins the first tie; timeout counter 0.
- Reset mid-transfer: at the next edge psel/penable drop to 0, no ack is issued, and the transfer is lost.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if req!=0, grant and go to SETUP.
  - Only one requester active: grant it.
  - Both active: grant ~last_gnt.
  - On grant: last_gnt<=grant, owner<=grant; latch addr/write/wdata of the granted requester into paddr/pwrite/pwdata.
  - Also set psel=1 for the next cycle.
- SETUP: psel=1, penable=0; go to ACCESS; penable=1 next cycle.
- ACCESS: psel=1, penable=1; count cycles.
  - pready=1: capture rdata<=prdata if read, else 0; err<=pslverr; drop psel/penable; go to RESP.
  - pready=0 and TIMEOUT!=0 and count==TIMEOUT-1: abort; drop psel/penable; rdata<=0; err<=1; timeout_evt<=1; go to RESP.
- RESP: ack[owner]=1 for exactly one cycle; rdata/err/timeout_evt valid; next state IDLE.
  - Requester must drop req in the cycle after ack.
  - IDLE re-samples req one cycle after RESP.
- Latency:
  - req seen in IDLE at cycle 0 → psel at c1, penable at c2, ack at c3 + wait states.
  - Minimum 4 cycles per transfer; no back-to-back overlap.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS and hold their last value afterwards.
- psel is never high in IDLE or RESP; penable only in ACCESS.
- rdata/err hold their value until the next capture. ack and timeout_evt are pulses.
- The timeout counter clears on entry to SETUP. pslverr with pready=1 ends the transfer normally with err=1 and timeout_evt=0.
- req dropped before ack is a requester protocol violation: the transfer completes and acks anyway; the arbiter does not cancel.
- Changes on req of the non-owner during a transfer are ignored until IDLE.

Test Plan:
1. Req 0 read, addr 0x1000_0004; slave pready=1 first ACCESS cycle, prdata 0xA5A5_0001 → psel c1, penable c2, ack=2'b01 at c3, rdata 0xA5A5_0001, err 0, owner 0.
2. After reset, req=2'b11 held, each requester re-asserting after its ack → grant order 0,1,0,1 over 4 transfers; paddr matches granted addr each time.
3. Req 1 write, addr 0x1000_0100, wdata 0x0000_00FF; pready low 3 ACCESS cycles → paddr/pwdata/pwrite stable 5 cycles; ack=2'b10 at c6; rdata 0.
4. Req 0 write with pslverr=1, pready=1 → ack=2'b01, err 1, timeout_evt 0.
5. TIMEOUT=8, req 1 read, pready held 0 → psel drops after 8 ACCESS cycles; ack=2'b10 with err 1, rdata 0, timeout_evt pulse in same cycle.
6. rst pulsed during ACCESS of req 0 → next cycle psel=0, penable=0, ack=0, owner 0; then req=2'b11 → requester 0 granted first.
